// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock supervisor on the free-running reference clock: pulses PLL reset,
// waits for a stable lock with timeout/retry, then releases a registered system reset.
module pll_reset_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int CNT_W               = 17,
  parameter int RELOCK_W            = 8
) (
  input  logic                refclk,
  input  logic                rst_n,
  input  logic                pll_locked,
  input  logic                restart,
  output logic                pll_rst,
  output logic                sys_rst_n,
  output logic                ready,
  output logic                timeout_err,
  output logic [RELOCK_W-1:0] relock_count
);

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       sync_q;
  logic             locked_s;
  logic             tout_set;
  logic             relock_inc;

  // pll_locked is asynchronous to refclk; only the synchronized copy is used
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], pll_locked};
  end
  assign locked_s = sync_q[1];

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    tout_set   = 1'b0;
    relock_inc = 1'b0;
    if (restart) begin
      state_nxt = PLL_RESET;
      cnt_nxt   = '0;
    end else begin
      case (state)
        PLL_RESET: begin
          if (cnt == RST_LAST) begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = '0;
          end else cnt_nxt = cnt + 1'b1;
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_nxt = STABLE;
            cnt_nxt   = '0;
          end else if (cnt == TO_LAST) begin
            state_nxt = PLL_RESET;
            cnt_nxt   = '0;
            tout_set  = 1'b1;
          end else cnt_nxt = cnt + 1'b1;
        end
        STABLE: begin
          // a lock glitch only restarts qualification, the PLL is not reset
          if (!locked_s) begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = '0;
          end else if (cnt == STB_LAST) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end else cnt_nxt = cnt + 1'b1;
        end
        RUN: begin
          cnt_nxt = '0;
          if (!locked_s) begin
            state_nxt  = PLL_RESET;
            relock_inc = 1'b1;
          end
        end
        default: begin
          state_nxt = PLL_RESET;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // outputs decoded from the next state so they move on the same edge as the state
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= PLL_RESET;
      cnt          <= '0;
      pll_rst      <= 1'b1;
      sys_rst_n    <= 1'b0;
      ready        <= 1'b0;
      timeout_err  <= 1'b0;
      relock_count <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pll_rst   <= (state_nxt == PLL_RESET);
      sys_rst_n <= (state_nxt == RUN);
      ready     <= (state_nxt == RUN);
      if (tout_set) timeout_err <= 1'b1;
      if (relock_inc && (relock_count != '1)) relock_count <= relock_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed vector table, hand-written corner sequences
// and random lock/restart traffic checked against a phase/age reference model.
module tb_pll_reset_sequencer;

  localparam int RP = 4;
  localparam int LS = 8;
  localparam int LT = 32;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       timeout_err;
  logic [7:0] relock_count;

  int n_cmp = 0;
  int n_bad = 0;

  pll_reset_sequencer #(
    .RST_PULSE_CYCLES(RP), .LOCK_STABLE_CYCLES(LS), .LOCK_TIMEOUT_CYCLES(LT),
    .CNT_W(6), .RELOCK_W(8)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .restart(restart),
    .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .ready(ready),
    .timeout_err(timeout_err), .relock_count(relock_count)
  );

  always #5 refclk = ~refclk;

  // reference model: current phase, edges spent in it, and the two sampled lock levels
  localparam int P_RST = 0, P_WAIT = 1, P_STB = 2, P_RUN = 3;
  int     m_phase, m_age, m_rel;
  bit     m_to;
  bit [1:0] m_sync;

  function automatic void model_reset();
    m_phase = P_RST; m_age = 0; m_rel = 0; m_to = 0; m_sync = 2'b00;
  endfunction

  function automatic void enter(input int p);
    m_phase = p; m_age = 0;
  endfunction

  function automatic void model_step(input bit lk, input bit rs);
    bit ls;
    ls = m_sync[1];
    m_sync = {m_sync[0], lk};
    m_age++;
    if (rs) enter(P_RST);
    else case (m_phase)
      P_RST:  if (m_age == RP) enter(P_WAIT);
      P_WAIT: if (ls) enter(P_STB);
              else if (m_age == LT) begin m_to = 1; enter(P_RST); end
      P_STB:  if (!ls) enter(P_WAIT);
              else if (m_age == LS) enter(P_RUN);
      default: if (!ls) begin
                 if (m_rel < 255) m_rel++;
                 enter(P_RST);
               end
    endcase
  endfunction

  function automatic logic [11:0] ev(input bit p, input bit s, input bit r, input bit t, input int rel);
    return {p, s, r, t, 8'(rel)};
  endfunction

  function automatic logic [11:0] model_vec();
    return ev(m_phase == P_RST, m_phase == P_RUN, m_phase == P_RUN, m_to, m_rel);
  endfunction

  function automatic logic [11:0] outv();
    return {pll_rst, sys_rst_n, ready, timeout_err, relock_count};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input bit lk, input bit rs);
    pll_locked = lk;
    restart    = rs;
    @(posedge refclk); #1;
    model_step(lk, rs);
    check("model", 32'(outv()), 32'(model_vec()));
    restart = 1'b0;
  endtask

  task automatic run_until_ready(input string name, output int n);
    n = 0;
    while (!ready && n < 80) begin tick(1'b1, 1'b0); n++; end
    check(name, 32'(ready), 32'd1);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge refclk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    int          n;
    bit          lk;
    bit          rs;
    logic [11:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int n;
    rst_n = 1'b0; pll_locked = 1'b0; restart = 1'b0;
    model_reset();

    // power-up sequence with timeout, lock, qualification and one relock
    tbl.push_back('{3,  1'b0, 1'b0, ev(1,0,0,0,0), "pulse_held"});
    tbl.push_back('{1,  1'b0, 1'b0, ev(0,0,0,0,0), "pulse_end"});
    tbl.push_back('{31, 1'b0, 1'b0, ev(0,0,0,0,0), "wait_before_timeout"});
    tbl.push_back('{1,  1'b0, 1'b0, ev(1,0,0,1,0), "timeout_retry"});
    tbl.push_back('{3,  1'b0, 1'b0, ev(1,0,0,1,0), "retry_pulse_held"});
    tbl.push_back('{1,  1'b0, 1'b0, ev(0,0,0,1,0), "retry_pulse_end"});
    tbl.push_back('{4,  1'b0, 1'b0, ev(0,0,0,1,0), "wait_no_lock"});
    tbl.push_back('{2,  1'b1, 1'b0, ev(0,0,0,1,0), "lock_in_sync"});
    tbl.push_back('{1,  1'b1, 1'b0, ev(0,0,0,1,0), "stable_entry"});
    tbl.push_back('{7,  1'b1, 1'b0, ev(0,0,0,1,0), "stable_window"});
    tbl.push_back('{1,  1'b1, 1'b0, ev(0,1,1,1,0), "run_release"});
    tbl.push_back('{1,  1'b0, 1'b0, ev(0,1,1,1,0), "loss_sync1"});
    tbl.push_back('{1,  1'b0, 1'b0, ev(0,1,1,1,0), "loss_sync2"});
    tbl.push_back('{1,  1'b0, 1'b0, ev(1,0,0,1,1), "loss_relock"});
    tbl.push_back('{3,  1'b0, 1'b0, ev(1,0,0,1,1), "relock_pulse"});
    tbl.push_back('{1,  1'b0, 1'b0, ev(0,0,0,1,1), "relock_pulse_end"});

    repeat (2) @(posedge refclk);
    #1 check("reset_state", 32'(outv()), 32'(ev(1,0,0,0,0)));
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      repeat (tbl[i].n) tick(tbl[i].lk, tbl[i].rs);
      check(tbl[i].name, 32'(outv()), 32'(tbl[i].exp));
    end

    // restart on the same edge the synchronized lock falls in RUN
    run_until_ready("reach_run_1", n);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    check("restart_over_loss", 32'(outv()), 32'(ev(1,0,0,1,1)));

    // restart mid-pulse stretches pll_rst to a full pulse from the restart
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0);
      check("restart_pulse_held", 32'(pll_rst), 32'd1);
    end
    tick(1'b0, 1'b0);
    check("restart_pulse_end", 32'(pll_rst), 32'd0);

    // relock counter saturation
    for (int it = 0; it < 300; it++) begin
      int k;
      run_until_ready("sat_reach_run", n);
      k = 0;
      while (ready && k < 10) begin tick(1'b0, 1'b0); k++; end
      check("sat_loss_seen", 32'(pll_rst), 32'd1);
    end
    check("relock_saturated", 32'(relock_count), 32'd255);

    // asynchronous reset mid-RUN
    run_until_ready("reach_run_2", n);
    tick(1'b1, 1'b0);
    #3 rst_n = 1'b0;
    model_reset();
    #1 check("async_reset_run", 32'(outv()), 32'(ev(1,0,0,0,0)));
    @(posedge refclk); #1 rst_n = 1'b1;

    // lock glitch in STABLE: back to WAIT_LOCK without a PLL pulse, window restarts
    repeat (4) tick(1'b0, 1'b0);
    repeat (3) tick(1'b1, 1'b0);
    repeat (5) tick(1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0);
      check("glitch_no_pulse", 32'({pll_rst, ready}), 32'd0);
    end
    run_until_ready("glitch_relock", n);
    check("relock_window_len", 32'(n), 32'(2 + 1 + LS));

    // asynchronous reset mid-STABLE
    tick(1'b1, 1'b1);
    repeat (4) tick(1'b1, 1'b0);
    repeat (4) tick(1'b1, 1'b0);
    check("in_stable", 32'({pll_rst, sys_rst_n, ready}), 32'd0);
    #3 rst_n = 1'b0;
    model_reset();
    #1 check("async_reset_stable", 32'(outv()), 32'(ev(1,0,0,0,0)));
    @(posedge refclk); #1 rst_n = 1'b1;

    // random lock runs and sparse restarts against the model
    begin
      bit lk = 1'b0;
      int left = 0;
      for (int c = 0; c < 4000; c++) begin
        if (left == 0) begin
          lk   = ($urandom_range(0, 3) != 0);
          left = $urandom_range(1, 40);
        end
        left--;
        tick(lk, $urandom_range(0, 99) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
